// File: rtl/irrig_pkg.sv
// Shared types for the irrigation scheduler: FSM states, grant encoding and
// the thermometer-coded tank level constants.
package irrig_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    SPRINKLE = 3'd2,
    DRIP     = 3'd3,
    CLEAN    = 3'd4,
    ERROR    = 3'd5
  } state_t;

  typedef enum logic {
    GRANT_ASP = 1'b0,
    GRANT_GOT = 1'b1
  } grant_t;

  localparam logic [2:0] LEVEL_EMPTY = 3'b000;
  localparam logic [2:0] LEVEL_LOW   = 3'b001;
  localparam logic [2:0] LEVEL_MID   = 3'b011;
  localparam logic [2:0] LEVEL_FULL  = 3'b111;

  localparam int TIMER_W = 8;

  function automatic logic level_valid(input logic [2:0] lv);
    return (lv == LEVEL_EMPTY) || (lv == LEVEL_LOW) ||
           (lv == LEVEL_MID)   || (lv == LEVEL_FULL);
  endfunction

endpackage

// File: rtl/irrigation_scheduler_tick_timer.sv
// Loadable tick-enabled down-counter; done flags the tick that will bring
// the count to zero, so a load of N expires on the Nth following tick.
module tick_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/irrigation_scheduler.sv
// Tank-fed irrigation scheduler: fill / sprinkle / drip / clean FSM with
// round-robin request arbitration. Optional doser enabled by FERTILIZER_EN.
module irrigation_scheduler
  import irrig_pkg::*;
#(
  parameter int ASP_TICKS    = 8,
  parameter int GOT_TICKS    = 12,
  parameter int CLEAN_TICKS  = 4,
  parameter int FILL_TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       asp_req,
  input  logic       got_req,
  input  logic       adb_req,
  input  logic [2:0] level,
  output logic       valve_fill,
  output logic       valve_asp,
  output logic       valve_got,
  output logic       dose_adb,
  output logic       clean_active,
  output logic       erro,
  output logic [2:0] state
);

  state_t               cur;
  state_t               nxt;
  grant_t               last_grant;
  logic                 timer_load;
  logic [TIMER_W-1:0]   timer_val;
  logic                 timer_done;

  // One timer serves every phase: the timed states are mutually exclusive.
  tick_timer #(.W(TIMER_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .tick     (tick),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_comb begin
    nxt        = cur;
    timer_load = 1'b0;
    timer_val  = '0;
    if (tick && (cur != ERROR)) begin
      if (!level_valid(level)) begin
        nxt = ERROR;
      end else begin
        case (cur)
          IDLE: begin
            if (level == LEVEL_EMPTY) begin
              nxt        = FILL;
              timer_load = 1'b1;
              timer_val  = TIMER_W'(FILL_TIMEOUT);
            end else if (asp_req && (!got_req || (last_grant == GRANT_GOT))) begin
              nxt        = SPRINKLE;
              timer_load = 1'b1;
              timer_val  = TIMER_W'(ASP_TICKS);
            end else if (got_req) begin
              nxt        = DRIP;
              timer_load = 1'b1;
              timer_val  = TIMER_W'(GOT_TICKS);
            end
          end
          FILL: begin
            if (level == LEVEL_FULL) begin
              nxt = IDLE;
            end else if (timer_done) begin
              nxt = ERROR;
            end
          end
          SPRINKLE, DRIP: begin
            if (level == LEVEL_EMPTY) begin
              nxt        = FILL;
              timer_load = 1'b1;
              timer_val  = TIMER_W'(FILL_TIMEOUT);
            end else if (timer_done) begin
              nxt        = CLEAN;
              timer_load = 1'b1;
              timer_val  = TIMER_W'(CLEAN_TICKS);
            end
          end
          CLEAN: begin
            if (timer_done) begin
              nxt = IDLE;
            end
          end
          default: nxt = cur;
        endcase
      end
    end
  end

  // Outputs are decoded from the next state so they line up with state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur          <= IDLE;
      last_grant   <= GRANT_GOT;
      valve_fill   <= 1'b0;
      valve_asp    <= 1'b0;
      valve_got    <= 1'b0;
      clean_active <= 1'b0;
      erro         <= 1'b0;
    end else begin
      cur          <= nxt;
      valve_fill   <= (nxt == FILL);
      valve_asp    <= (nxt == SPRINKLE);
      valve_got    <= (nxt == DRIP);
      clean_active <= (nxt == CLEAN);
      erro         <= (nxt == ERROR);
      if ((cur == SPRINKLE) && (nxt == CLEAN)) begin
        last_grant <= GRANT_ASP;
      end else if ((cur == DRIP) && (nxt == CLEAN)) begin
        last_grant <= GRANT_GOT;
      end
    end
  end

  assign state = cur;

`ifdef FERTILIZER_EN
  logic [1:0] dose_left;

  // Doser runs for the first two ticks of a sprinkler cycle granted with adb_req.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dose_left <= 2'd0;
      dose_adb  <= 1'b0;
    end else if (tick) begin
      if ((cur == IDLE) && (nxt == SPRINKLE)) begin
        dose_left <= adb_req ? 2'd2 : 2'd0;
        dose_adb  <= adb_req;
      end else if ((cur == SPRINKLE) && (nxt == SPRINKLE)) begin
        if (dose_left != 2'd0) begin
          dose_left <= dose_left - 2'd1;
        end
        dose_adb <= (dose_left == 2'd2);
      end else begin
        dose_left <= 2'd0;
        dose_adb  <= 1'b0;
      end
    end
  end
`else
  logic unused_adb;
  assign unused_adb = adb_req;
  assign dose_adb   = 1'b0;
`endif

endmodule

// File: doc/irrigation_scheduler.md
IRRIGATION_SCHEDULER -- requirements
Module: irrigation_scheduler

Interface
REQ-001 SHALL have parameter ASP_TICKS, default 8, sprinkler cycle length in ticks.
REQ-002 SHALL have parameter GOT_TICKS, default 12, drip cycle length in ticks.
REQ-003 SHALL have parameter CLEAN_TICKS, default 4, post-irrigation cleaning length in ticks.
REQ-004 SHALL have parameter FILL_TIMEOUT, default 16, maximum fill duration in ticks.
REQ-005 SHALL have ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle enable from the divided-clock chain
- asp_req  in  1  sprinkler request, level-sensitive
- got_req  in  1  drip request, level-sensitive
- adb_req  in  1  fertilizer request
- level  in  3  tank level, thermometer code
- valve_fill  out  1  tank inlet valve
- valve_asp  out  1  sprinkler valve
- valve_got  out  1  drip valve
- dose_adb  out  1  fertilizer doser
- clean_active  out  1  cleaning in progress
- erro  out  1  sticky fault
- state  out  3  current FSM state

Function
REQ-006 SHALL use FSM states IDLE, FILL, SPRINKLE, DRIP, CLEAN, ERROR; all transitions and counter decrements occur only on clock edges where tick=1.
REQ-007 SHALL treat level codes 000 (empty), 001, 011, 111 (full) as valid; any other code on a tick in any non-ERROR state SHALL force ERROR.
REQ-008 IDLE: level=000 -> FILL, taking priority over requests.
REQ-009 IDLE, level!=000: exactly one request -> grant it; both -> grant the requester not granted last (round-robin); none -> stay.
REQ-010 On grant, the duration counter SHALL load ASP_TICKS or GOT_TICKS; SPRINKLE drives valve_asp=1, DRIP drives valve_got=1.
REQ-011 On counter reaching 0, SHALL enter CLEAN, load CLEAN_TICKS, update the last-grant pointer.
REQ-012 Level=000 during SPRINKLE/DRIP SHALL abort to FILL; remaining ticks discarded; last-grant pointer NOT updated.
REQ-013 CLEAN SHALL drive clean_active=1, run to completion regardless of level or requests, then return to IDLE.
REQ-014 FILL SHALL drive valve_fill=1, exit to IDLE when level=111, and enter ERROR if FILL_TIMEOUT ticks elapse without 111.
REQ-015 ERROR SHALL drive erro=1 with all valves, dose_adb and clean_active at 0, and hold until reset.
REQ-016 All outputs SHALL be registered, valid the clock after the deciding tick edge; exactly one of valve_fill/valve_asp/valve_got/clean_active is high outside IDLE/ERROR.
REQ-017 Requests deasserting mid-cycle SHALL NOT shorten the cycle.

Reset
REQ-018 reset=0 SHALL immediately clear: state=IDLE, all outputs 0, counters 0, last-grant=DRIP (sprinkler wins the first tie), erro=0.
REQ-019 Reset asserted mid-operation SHALL close all valves in the same cycle without waiting for a clock edge.

Configuration
REQ-020 With FERTILIZER_EN defined: adb_req sampled at a SPRINKLE grant; if 1, dose_adb=1 for the first 2 ticks of that SPRINKLE; never during DRIP.
REQ-021 Without FERTILIZER_EN: adb_req ignored, dose_adb constant 0.

Structure
REQ-022 Package irrig_pkg SHALL hold the state enum, valid level constants and grant encoding.
REQ-023 One sub-module tick_timer (loadable down-counter, tick-enabled, done flag) SHALL be instantiated for duration/clean and fill-timeout counts.

Verification
REQ-024 level=011, asp_req=got_req=1 from reset -> SPRINKLE 8 ticks, CLEAN 4, then DRIP 12 ticks.
REQ-025 level=000 after reset, raised to 111 at tick 5 -> valve_fill 1 for ticks 1-5, IDLE after.
REQ-026 level held 001 in FILL -> erro=1 after 16 ticks, all valves 0, persists until reset.
REQ-027 DRIP active, level->000 at tick 3 -> FILL; at 111 with both requests pending, DRIP regranted.
REQ-028 level=010 on any tick -> ERROR next cycle; reset=0 mid-SPRINKLE -> valve_asp 0 asynchronously.
REQ-029 FERTILIZER_EN, adb_req=1 at SPRINKLE grant -> dose_adb 1 for 2 ticks; undefined macro -> dose_adb always 0.
